hwpe_ctrl_uloop: RTL and testbench
==================================

Name: hwpe_ctrl_uloop

Overview:
- Parametrised nested-loop microcode engine; next generation of the streamer base-offset ucode processor.
- Walks up to NB_LOOPS nested loop counters and runs per-loop micro-op lists on NB_REG writable offset registers. Operands come from those registers and from NB_RO_REG read-only registers.
- Publishes each iteration's offsets and indices through a valid/ready handshake, so downstream streamers can backpressure it.
- New relative to the previous generation: backpressure, SUB/NOP opcodes, zero-op loops, range-0 tolerance, and per-level wrap flags.

Parameters:
- NB_LOOPS, 6, number of nested loop levels (level 0 innermost).
- LENGTH, 28, number of microcode slots.
- NB_REG, 5, writable offset registers.
- NB_RO_REG, 16, read-only operand registers.
- REG_WIDTH, 32, register/offset width.
- CNT_WIDTH, 16, loop counter width.
- Derived: AW=$clog2(LENGTH), RW=$clog2(NB_REG+NB_RO_REG).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous clear, same effect as reset.
- start_i  in  1  start walk; honoured only in IDLE.
- loop_addr_i  in  NB_LOOPS x AW  first ucode slot of each level's op list.
- loop_nb_ops_i  in  NB_LOOPS x (AW+1)  op count per level; 0 allowed.
- loop_range_i  in  NB_LOOPS x CNT_WIDTH  iteration count per level; 0 treated as 1.
- code_op_i  in  LENGTH x 2  opcode: 00 NOP, 01 MOV a=b, 10 ADD a=a+b, 11 SUB a=a-b.
- code_a_i  in  LENGTH x RW  destination/first operand index.
- code_b_i  in  LENGTH x RW  second operand index.
- registers_read_i  in  NB_RO_REG x REG_WIDTH  read-only operands.
- ready_i  in  1  consumer accepts current emission.
- valid_o  out  1  emission valid.
- offs_o  out  NB_REG x REG_WIDTH  current offset registers.
- idx_o  out  NB_LOOPS x CNT_WIDTH  current loop indices.
- wrap_o  out  NB_LOOPS  idx_o[j]==last_j per level, qualified by valid_o.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse at end of walk.

Behaviour:
- Reset/clear: state IDLE; regs, idx, op counter = 0; valid_o, wrap_o, busy_o, done_o = 0. clear_i has priority over every other event.
- Config inputs must be stable while busy_o=1; changing them mid-walk gives undefined results.
- last_j = max(loop_range_i[j],1)-1.
- Operand index map: 0..NB_REG-1 → regs; NB_REG.. → registers_read_i; indices beyond that read 0.
- Writes with a>=NB_REG are dropped. Arithmetic wraps modulo 2^REG_WIDTH.
- FSM IDLE, EMIT, EXEC, DONE:
  - IDLE: start_i → clear regs and idx to 0, go to EMIT next cycle. start_i in any other state is ignored.
  - EMIT: valid_o=1. Outputs are the register contents and are held stable while ready_i=0; no ops execute.
    - On valid_o&ready_i with all idx[j]==last_j → DONE.
    - Otherwise L = lowest j with idx[j]<last_j; idx[L]++, idx[j<L]=0 (registered same edge); load op counter 0; go to EXEC.
  - EXEC: one op per cycle at slot loop_addr_i[L]+opcnt, written at clock edge. Leave to EMIT after the op with opcnt==loop_nb_ops_i[L]-1. If loop_nb_ops_i[L]==0, spend one idle cycle and leave to EMIT.
  - DONE: done_o=1 for one cycle, then IDLE. offs_o/idx_o retain final values until the next start or clear.
- Timing:
  - First emission (all zero) appears 1 cycle after start_i.
  - valid_o drops for max(nb_ops[L],1) cycles after every handshake. Each EXEC op sees results of prior ops in the same list.
  - Total emissions = product of max(range_j,1).

Test Plan:
- Test 1, two-level walk:
  - Setup: NB_LOOPS used=2 (upper levels range 1, nb_ops 0), ranges {3,2}, ro0=4, ro1=100, ro2=0. Level0: ADD r0,ro0. Level1: ADD r1,ro1; MOV r0,ro2.
  - Expected (idx0,idx1,r0,r1) emissions: (0,0,0,0),(1,0,4,0),(2,0,8,0),(0,1,0,100),(1,1,4,100),(2,1,8,100).
  - Then done_o pulses once, busy_o falls, wrap_o[0]=1 on emissions 3 and 6.
- Test 2, backpressure: same as Test 1 with ready_i low for 5 cycles at emission 2 → valid_o, offs_o, idx_o constant; r0 stays 4; sequence unchanged.
- Test 3, degenerate loops: level0 range 0, level1 range 1, all nb_ops 0 → exactly one emission (all zeros), then done_o. A level with nb_ops=0 and range 3 → 3 emissions, each separated by exactly one valid_o-low cycle.
- Test 4, arithmetic and index edge cases:
  - SUB r0,ro0 with ro0=1 from r0=0 → r0=0xFFFF_FFFF.
  - ADD with a=NB_REG → no register changes.
  - b index = NB_REG+NB_RO_REG → operand reads 0.
- Test 5, clear mid-walk: clear_i asserted mid-walk during EXEC → next cycle all outputs 0, state IDLE. Subsequent start_i restarts from idx 0, regs 0.
- Test 6, start while busy: start_i pulsed while busy → ignored, walk count unchanged. Reset asserted asynchronously mid-EMIT → valid_o drops immediately.

Source files
------------

// File: rtl/hwpe_ctrl_uloop_if.sv
// Emission channel of the nested-loop ucode engine: per-iteration offsets,
// loop indices and wrap flags under a valid/ready handshake.
interface hwpe_ctrl_uloop_if #(
  parameter int unsigned NB_LOOPS  = 6,
  parameter int unsigned NB_REG    = 5,
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16
) ();
  logic                                 valid;
  logic                                 ready;
  logic [NB_REG-1:0][REG_WIDTH-1:0]     offs;
  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]   idx;
  logic [NB_LOOPS-1:0]                  wrap;

  modport master (output valid, offs, idx, wrap, input ready);
  modport slave  (input valid, offs, idx, wrap, output ready);
endinterface

// File: rtl/hwpe_ctrl_uloop.sv
// Nested-loop microcode engine: walks NB_LOOPS counters, runs each level's op
// list on the offset registers and emits every iteration with backpressure.
module hwpe_ctrl_uloop #(
  parameter int unsigned NB_LOOPS  = 6,
  parameter int unsigned LENGTH    = 28,
  parameter int unsigned NB_REG    = 5,
  parameter int unsigned NB_RO_REG = 16,
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16,
  localparam int unsigned AW = $clog2(LENGTH),
  localparam int unsigned RW = $clog2(NB_REG + NB_RO_REG)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 clear_i,
  input  logic                                 start_i,
  input  logic [NB_LOOPS-1:0][AW-1:0]          loop_addr_i,
  input  logic [NB_LOOPS-1:0][AW:0]            loop_nb_ops_i,
  input  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]   loop_range_i,
  input  logic [LENGTH-1:0][1:0]               code_op_i,
  input  logic [LENGTH-1:0][RW-1:0]            code_a_i,
  input  logic [LENGTH-1:0][RW-1:0]            code_b_i,
  input  logic [NB_RO_REG-1:0][REG_WIDTH-1:0]  registers_read_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  hwpe_ctrl_uloop_if.master                    emit
);
  localparam int unsigned OW = AW + 1;
  localparam int unsigned LW = (NB_LOOPS > 1) ? $clog2(NB_LOOPS) : 1;

  typedef enum logic [1:0] {IDLE, EMIT, EXEC, DONE} state_e;

  state_e                             state;
  logic [NB_REG-1:0][REG_WIDTH-1:0]   regs;
  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] idx;
  logic [OW-1:0]                      opcnt;
  logic [LW-1:0]                      lvl, nxt_lvl;
  logic                               valid_q, busy_q, done_q;
  logic [NB_LOOPS-1:0]                at_last;

  // range 0 is treated as a single iteration
  for (genvar j = 0; j < NB_LOOPS; j++) begin : g_lvl
    logic [CNT_WIDTH-1:0] last;
    assign last       = (loop_range_i[j] == '0) ? '0 : loop_range_i[j] - CNT_WIDTH'(1);
    assign at_last[j] = (idx[j] == last);
  end

  always_comb begin
    nxt_lvl = '0;
    for (int j = NB_LOOPS - 1; j >= 0; j--)
      if (!at_last[j]) nxt_lvl = LW'(j);
  end

  logic [OW-1:0]        nb_ops, slot;
  logic [1:0]           op;
  logic [RW-1:0]        ra, rb;
  logic [REG_WIDTH-1:0] opa, opb, res;
  logic                 we, last_op;

  assign nb_ops = loop_nb_ops_i[lvl];
  assign slot   = {1'b0, loop_addr_i[lvl]} + opcnt;

  // slots past LENGTH decode as NOP
  always_comb begin
    op = 2'b00; ra = '0; rb = '0;
    for (int s = 0; s < LENGTH; s++)
      if (slot == OW'(s)) begin
        op = code_op_i[s]; ra = code_a_i[s]; rb = code_b_i[s];
      end
  end

  always_comb begin
    opa = '0; opb = '0;
    for (int i = 0; i < NB_REG; i++) begin
      if (ra == RW'(i)) opa = regs[i];
      if (rb == RW'(i)) opb = regs[i];
    end
    for (int i = 0; i < NB_RO_REG; i++)
      if (rb == RW'(NB_REG + i)) opb = registers_read_i[i];
  end

  always_comb begin
    case (op)
      2'b01:   res = opb;
      2'b10:   res = opa + opb;
      default: res = opa - opb;
    endcase
  end

  assign we      = (op != 2'b00) && (nb_ops != '0);
  assign last_op = ({1'b0, opcnt} + (OW+1)'(1)) >= {1'b0, nb_ops};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE; regs <= '0; idx <= '0; opcnt <= '0; lvl <= '0;
      valid_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
    end else if (clear_i) begin
      state <= IDLE; regs <= '0; idx <= '0; opcnt <= '0; lvl <= '0;
      valid_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          regs <= '0; idx <= '0;
          state <= EMIT; valid_q <= 1'b1; busy_q <= 1'b1;
        end
        EMIT: if (emit.ready) begin
          valid_q <= 1'b0;
          if (&at_last) begin
            state <= DONE; done_q <= 1'b1;
          end else begin
            for (int j = 0; j < NB_LOOPS; j++)
              if (LW'(j) < nxt_lvl)       idx[j] <= '0;
              else if (LW'(j) == nxt_lvl) idx[j] <= idx[j] + CNT_WIDTH'(1);
            lvl <= nxt_lvl; opcnt <= '0; state <= EXEC;
          end
        end
        EXEC: begin
          for (int i = 0; i < NB_REG; i++)
            if (we && ra == RW'(i)) regs[i] <= res;
          opcnt <= opcnt + OW'(1);
          if (last_op) begin
            state <= EMIT; valid_q <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE; done_q <= 1'b0; busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign emit.valid = valid_q;
  assign emit.offs  = regs;
  assign emit.idx   = idx;
  assign emit.wrap  = at_last & {NB_LOOPS{valid_q}};
  assign busy_o     = busy_q;
  assign done_o     = done_q;
endmodule

// File: tb/tb_hwpe_ctrl_uloop.sv
// Bench for hwpe_ctrl_uloop: table of two-level walks checked through an
// emission scoreboard, plus clear, async reset and start-while-busy sequences.
module tb_hwpe_ctrl_uloop;
  localparam int NB_LOOPS = 6, LENGTH = 28, NB_REG = 5, NB_RO_REG = 16;
  localparam int REG_WIDTH = 32, CNT_WIDTH = 16, AW = 5, RW = 5;

  logic clk_i = 1'b0, rst_ni = 1'b0, clear_i = 1'b0, start_i = 1'b0;
  logic [NB_LOOPS-1:0][AW-1:0]          loop_addr;
  logic [NB_LOOPS-1:0][AW:0]            loop_nb;
  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]   loop_range;
  logic [LENGTH-1:0][1:0]               code_op;
  logic [LENGTH-1:0][RW-1:0]            code_a, code_b;
  logic [NB_RO_REG-1:0][REG_WIDTH-1:0]  ro;
  logic busy, done;

  hwpe_ctrl_uloop_if #(.NB_LOOPS(NB_LOOPS), .NB_REG(NB_REG), .REG_WIDTH(REG_WIDTH),
                       .CNT_WIDTH(CNT_WIDTH)) u_if ();

  hwpe_ctrl_uloop #(.NB_LOOPS(NB_LOOPS), .LENGTH(LENGTH), .NB_REG(NB_REG),
                    .NB_RO_REG(NB_RO_REG), .REG_WIDTH(REG_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .loop_addr_i(loop_addr), .loop_nb_ops_i(loop_nb), .loop_range_i(loop_range),
    .code_op_i(code_op), .code_a_i(code_a), .code_b_i(code_b),
    .registers_read_i(ro), .busy_o(busy), .done_o(done), .emit(u_if)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int rng0, rng1, nb0, nb1;
    logic [1:0] op0;
    int a0, b0;
    logic [31:0] ro0, ro1, ro2;
    int nexp;
    logic [7:0][15:0] ei0, ei1;
    logic [7:0][31:0] er0, er1;
    logic [7:0][3:0]  gap;
  } vec_t;

  typedef struct { logic [255:0] val; int gap; } exp_t;

  vec_t vt[6];
  exp_t sb[$];
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  function automatic logic [255:0] pk(logic [15:0] i0, logic [15:0] i1, logic [31:0] r0,
                                      logic [31:0] r1, logic [5:0] w, logic b);
    return 256'({i0, i1, r0, r1, w, b});
  endfunction

  function automatic logic [255:0] act();
    return pk(u_if.idx[0], u_if.idx[1], u_if.offs[0], u_if.offs[1], u_if.wrap, busy);
  endfunction

  function automatic logic [5:0] wexp(int v, logic [15:0] i0, logic [15:0] i1);
    int l0, l1;
    l0 = (vt[v].rng0 == 0) ? 0 : vt[v].rng0 - 1;
    l1 = (vt[v].rng1 == 0) ? 0 : vt[v].rng1 - 1;
    return {4'b1111, i1 == 16'(l1), i0 == 16'(l0)};
  endfunction

  task automatic em(input int v, input int k, input int i0, input int i1,
                    input logic [31:0] r0, input logic [31:0] r1, input int g);
    vt[v].ei0[k] = 16'(i0); vt[v].ei1[k] = 16'(i1);
    vt[v].er0[k] = r0;      vt[v].er1[k] = r1;
    vt[v].gap[k] = 4'(g);   vt[v].nexp = k + 1;
  endtask

  // slot0: level-0 op under test; slots 1-2: level-1 list ADD r1,ro1 ; MOV r0,ro2
  task automatic cfg(input int v);
    loop_addr = '0; loop_addr[1] = 5'd1;
    loop_nb = '0; loop_nb[0] = 6'(vt[v].nb0); loop_nb[1] = 6'(vt[v].nb1);
    for (int j = 0; j < NB_LOOPS; j++) loop_range[j] = 16'd1;
    loop_range[2] = 16'd0;
    loop_range[0] = 16'(vt[v].rng0); loop_range[1] = 16'(vt[v].rng1);
    code_op = '0; code_a = '0; code_b = '0;
    code_op[0] = vt[v].op0; code_a[0] = 5'(vt[v].a0); code_b[0] = 5'(vt[v].b0);
    code_op[1] = 2'b10; code_a[1] = 5'd1; code_b[1] = 5'd6;
    code_op[2] = 2'b01; code_a[2] = 5'd0; code_b[2] = 5'd7;
    for (int i = 0; i < NB_RO_REG; i++) ro[i] = 32'h5A5A_0000 + 32'(i);
    ro[0] = vt[v].ro0; ro[1] = vt[v].ro1; ro[2] = vt[v].ro2;
  endtask

  task automatic run_walk(input int v, input int bp_em, input int bp_len, input int st_em);
    int k, gap, stall, cyc, n;
    bit fin;
    exp_t e;
    cfg(v);
    for (int i = 0; i < vt[v].nexp; i++) begin
      e.val = pk(vt[v].ei0[i], vt[v].ei1[i], vt[v].er0[i], vt[v].er1[i],
                 wexp(v, vt[v].ei0[i], vt[v].ei1[i]), 1'b1);
      e.gap = int'(vt[v].gap[i]);
      sb.push_back(e);
    end
    @(negedge clk_i) start_i = 1'b1;
    @(negedge clk_i) start_i = 1'b0;
    k = 0; gap = 0; stall = 0; cyc = 0; fin = 1'b0;
    while (!fin && cyc < 400) begin
      start_i = 1'b0; u_if.ready = 1'b1;
      if (u_if.valid) begin
        if (k == st_em) start_i = 1'b1;
        if (sb.size() == 0) chk("extra_emit", u_if.valid, 1'b0);
        else if (k == bp_em && stall < bp_len) begin
          u_if.ready = 1'b0; stall++;
          chk("held", act(), sb[0].val);
        end else begin
          e = sb.pop_front();
          chk("emit", act(), e.val);
          chk("gap", 256'(gap), 256'(e.gap));
          gap = 0; k++;
        end
      end else begin
        chk("wrap_idle", u_if.wrap, '0);
        gap++;
      end
      if (done) fin = 1'b1;
      @(negedge clk_i); cyc++;
    end
    start_i = 1'b0;
    n = vt[v].nexp - 1;
    chk("timeout", fin, 1'b1);
    chk("leftover", 256'(sb.size()), '0);
    sb.delete();
    chk("done_pulse", {done, busy}, 2'b00);
    chk("idx_hold", {u_if.idx[0], u_if.idx[1]}, {vt[v].ei0[n], vt[v].ei1[n]});
  endtask

  initial begin
    // V0: two-level walk
    vt[0].rng0 = 3; vt[0].rng1 = 2; vt[0].nb0 = 1; vt[0].nb1 = 2;
    vt[0].op0 = 2'b10; vt[0].a0 = 0; vt[0].b0 = 5;
    vt[0].ro0 = 32'd4; vt[0].ro1 = 32'd100; vt[0].ro2 = 32'd0;
    em(0, 0, 0, 0, 0, 0, 0);   em(0, 1, 1, 0, 4, 0, 1);   em(0, 2, 2, 0, 8, 0, 1);
    em(0, 3, 0, 1, 0, 100, 2); em(0, 4, 1, 1, 4, 100, 1); em(0, 5, 2, 1, 8, 100, 1);
    // V1: SUB wraps below zero
    vt[1] = vt[0]; vt[1].rng0 = 2; vt[1].rng1 = 1; vt[1].op0 = 2'b11; vt[1].ro0 = 32'd1;
    em(1, 0, 0, 0, 0, 0, 0); em(1, 1, 1, 0, 32'hFFFF_FFFF, 0, 1);
    // V2: destination index NB_REG is dropped
    vt[2] = vt[1]; vt[2].op0 = 2'b10; vt[2].a0 = 5; vt[2].ro0 = 32'd7;
    em(2, 0, 0, 0, 0, 0, 0); em(2, 1, 1, 0, 0, 0, 1);
    // V3: operand index NB_REG+NB_RO_REG reads zero
    vt[3] = vt[0]; vt[3].rng0 = 2; vt[3].b0 = 21; vt[3].ro2 = 32'd9;
    em(3, 0, 0, 0, 0, 0, 0); em(3, 1, 1, 0, 0, 0, 1);
    em(3, 2, 0, 1, 9, 100, 2); em(3, 3, 1, 1, 9, 100, 1);
    // V4: range 0 / range 1, no ops -> single emission
    vt[4] = vt[0]; vt[4].rng0 = 0; vt[4].rng1 = 1; vt[4].nb0 = 0; vt[4].nb1 = 0;
    em(4, 0, 0, 0, 0, 0, 0);
    // V5: zero-op level of range 3 -> one idle cycle between emissions
    vt[5] = vt[4]; vt[5].rng0 = 3;
    em(5, 0, 0, 0, 0, 0, 0); em(5, 1, 1, 0, 0, 0, 1); em(5, 2, 2, 0, 0, 0, 1);

    u_if.ready = 1'b1;
    cfg(0);
    repeat (2) @(negedge clk_i);
    chk("rst_ctl", {u_if.valid, busy, done, u_if.wrap}, '0);
    chk("rst_data", {u_if.offs, u_if.idx}, '0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("idle_ctl", {u_if.valid, busy, done, u_if.wrap}, '0);

    for (int v = 0; v < 6; v++) run_walk(v, -1, 0, -1);
    run_walk(0, 1, 5, -1);   // backpressure at emission 2
    run_walk(0, -1, 0, 2);   // start pulsed mid-walk

    // clear during EXEC
    cfg(0);
    @(negedge clk_i) start_i = 1'b1;
    @(negedge clk_i) start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("pre_clear", {u_if.valid, busy, u_if.idx[0], u_if.offs[0]},
        {1'b0, 1'b1, 16'd2, 32'd4});
    clear_i = 1'b1;
    @(negedge clk_i) clear_i = 1'b0;
    chk("clr_ctl", {u_if.valid, busy, done, u_if.wrap}, '0);
    chk("clr_data", {u_if.offs, u_if.idx}, '0);
    run_walk(0, -1, 0, -1);

    // asynchronous reset while emitting
    cfg(0);
    @(negedge clk_i) start_i = 1'b1;
    @(negedge clk_i) start_i = 1'b0;
    u_if.ready = 1'b0;
    chk("pre_rst", u_if.valid, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_ctl", {u_if.valid, busy, done, u_if.wrap}, '0);
    chk("arst_data", {u_if.offs, u_if.idx}, '0);
    @(negedge clk_i) rst_ni = 1'b1;
    u_if.ready = 1'b1;
    run_walk(1, -1, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
